// File: rtl/bp_be_dispatch_queue_pkg.sv
// Shared constants and helpers for the dispatch queue slice.
package bp_be_dispatch_queue_pkg;

  localparam int dq_pkt_width_gp = 128;
  localparam int dq_els_gp       = 4;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bp_be_dispatch_queue_ptr.sv
// Circular wrap-bit pointer: clear beats load beats increment.
module bp_be_dispatch_queue_ptr #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               inc_i,
  output logic [width_p-1:0] cnt_o
);

  logic [width_p-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)    r_cnt <= '0;
    else if (clr_i)  r_cnt <= '0;
    else if (load_i) r_cnt <= load_val_i;
    else if (inc_i)  r_cnt <= r_cnt + width_p'(1);
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/bp_be_dispatch_queue.sv
// Speculative dispatch queue: entries stay resident until committed so a roll
// can replay from the oldest uncommitted packet.
module bp_be_dispatch_queue
  import bp_be_dispatch_queue_pkg::*;
#(
  parameter int pkt_width_p  = dq_pkt_width_gp,
  parameter int els_p        = dq_els_gp,
  parameter int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [pkt_width_p-1:0]  issue_pkt_i,
  input  logic                    issue_v_i,
  output logic                    issue_ready_o,
  output logic [pkt_width_p-1:0]  dispatch_pkt_o,
  output logic                    dispatch_v_o,
  input  logic                    dispatch_yumi_i,
  input  logic                    commit_i,
  input  logic                    roll_i,
  input  logic                    flush_i,
  output logic [ptr_width_lp-1:0] inflight_o,
  output logic                    empty_o
);

  localparam int idx_w_lp = ptr_width_lp - 1;

  if (!is_pow2(els_p)) begin : g_bad_els
    $error("els_p must be a power of two >= 2");
  end

  logic [ptr_width_lp-1:0] w_wptr, w_rptr, w_cptr, w_cptr_next;
  logic [ptr_width_lp-1:0] w_resident, w_pending, w_inflight;
  logic                    w_enq;
  logic [els_p-1:0][pkt_width_p-1:0] r_mem;

  assign w_resident = w_wptr - w_cptr;
  assign w_pending  = w_wptr - w_rptr;
  assign w_inflight = w_rptr - w_cptr;

  assign issue_ready_o  = (w_resident != ptr_width_lp'(els_p));
  assign dispatch_v_o   = (w_pending != '0);
  assign dispatch_pkt_o = r_mem[w_rptr[idx_w_lp-1:0]];
  assign inflight_o     = w_inflight;
  assign empty_o        = (w_resident == '0);

  assign w_enq       = issue_v_i & issue_ready_o & ~flush_i;
  // Roll rewinds to the commit pointer as it will be after this cycle's commit.
  assign w_cptr_next = w_cptr + ptr_width_lp'(commit_i);

  bp_be_dispatch_queue_ptr #(.width_p(ptr_width_lp)) u_wptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_i      (flush_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (w_enq),
    .cnt_o      (w_wptr)
  );

  bp_be_dispatch_queue_ptr #(.width_p(ptr_width_lp)) u_rptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_i      (flush_i),
    .load_i     (roll_i),
    .load_val_i (w_cptr_next),
    .inc_i      (dispatch_yumi_i),
    .cnt_o      (w_rptr)
  );

  bp_be_dispatch_queue_ptr #(.width_p(ptr_width_lp)) u_cptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_i      (flush_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (commit_i),
    .cnt_o      (w_cptr)
  );

  // Payload storage is intentionally left unreset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[w_wptr[idx_w_lp-1:0]] <= issue_pkt_i;
  end

`ifndef SYNTHESIS
  a_yumi_without_v: assert property (@(posedge clk_i) disable iff (!reset_i)
    dispatch_yumi_i |-> dispatch_v_o);
  a_commit_none_inflight: assert property (@(posedge clk_i) disable iff (!reset_i)
    commit_i |-> (w_inflight != '0));
`endif

endmodule

// File: tb/tb_bp_be_dispatch_queue.sv
// Directed vector bench for bp_be_dispatch_queue plus wrap and async-reset sequences.
module tb_bp_be_dispatch_queue;

  localparam int PW = 128;
  localparam int PTRW = 3;

  logic            clk, rst_n;
  logic [PW-1:0]   issue_pkt;
  logic            issue_v, issue_ready;
  logic [PW-1:0]   disp_pkt;
  logic            disp_v, yumi, commit, roll, flush;
  logic [PTRW-1:0] inflight;
  logic            empty;

  int n_chk = 0;
  int n_pass = 0;

  bp_be_dispatch_queue #(.pkt_width_p(PW), .els_p(4)) dut (
    .clk_i           (clk),
    .reset_i         (rst_n),
    .issue_pkt_i     (issue_pkt),
    .issue_v_i       (issue_v),
    .issue_ready_o   (issue_ready),
    .dispatch_pkt_o  (disp_pkt),
    .dispatch_v_o    (disp_v),
    .dispatch_yumi_i (yumi),
    .commit_i        (commit),
    .roll_i          (roll),
    .flush_i         (flush),
    .inflight_o      (inflight),
    .empty_o         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs describe the registered state seen before the row's inputs take effect.
  typedef struct {
    logic          iv;
    logic [PW-1:0] pkt;
    logic          y, c, r, f;
    logic          e_rdy, e_v;
    logic [PW-1:0] e_pkt;
    logic [PTRW-1:0] e_inf;
    logic          e_emp;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic iv, input logic [PW-1:0] pkt, input logic y, c, r, f,
                     input logic e_rdy, e_v, input logic [PW-1:0] e_pkt,
                     input int e_inf, input logic e_emp);
    vec_t v;
    v.iv = iv; v.pkt = pkt; v.y = y; v.c = c; v.r = r; v.f = f;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_pkt = e_pkt; v.e_inf = PTRW'(e_inf); v.e_emp = e_emp;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic iv, input logic [PW-1:0] pkt, input logic y, c, r, f);
    issue_v = iv; issue_pkt = pkt; yumi = y; commit = c; roll = r; flush = f;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ready"}, PW'(issue_ready), PW'(1));
    chk({tag, ".v"}, PW'(disp_v), PW'(0));
    chk({tag, ".inflight"}, PW'(inflight), PW'(0));
    chk({tag, ".empty"}, PW'(empty), PW'(1));
  endtask

  initial begin
    int sent, nd, m_infl, cyc;
    logic y_now, c_now;

    drive(0, '0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // in-order dispatch with yumi held from cycle 1
    add(1,'hA,0,0,0,0, 1,0,'0, 0,1);
    add(1,'hB,1,0,0,0, 1,1,'hA,0,0);
    add(1,'hC,1,0,0,0, 1,1,'hB,1,0);
    add(0,'0, 1,0,0,0, 1,1,'hC,2,0);
    add(0,'0, 0,1,0,0, 1,0,'0, 3,0);
    add(0,'0, 0,1,0,0, 1,0,'0, 2,0);
    add(0,'0, 0,1,0,0, 1,0,'0, 1,0);
    // fill to full, then commit+yumi+issue in one cycle
    add(1,'h1,0,0,0,0, 1,0,'0, 0,1);
    add(1,'h2,0,0,0,0, 1,1,'h1,0,0);
    add(1,'h3,0,0,0,0, 1,1,'h1,0,0);
    add(1,'h4,0,0,0,0, 1,1,'h1,0,0);
    add(0,'0, 1,0,0,0, 0,1,'h1,0,0);
    add(1,'h5,1,1,0,0, 0,1,'h2,1,0);
    add(0,'0, 1,1,0,0, 1,1,'h3,1,0);
    add(0,'0, 1,1,0,0, 1,1,'h4,1,0);
    add(0,'0, 0,1,0,0, 1,0,'0, 1,0);
    // dispatch A..D, commit A, roll with yumi -> replay from B
    add(1,'hA,0,0,0,0, 1,0,'0, 0,1);
    add(1,'hB,1,0,0,0, 1,1,'hA,0,0);
    add(1,'hC,1,0,0,0, 1,1,'hB,1,0);
    add(1,'hD,1,0,0,0, 1,1,'hC,2,0);
    add(0,'0, 0,1,0,0, 0,1,'hD,3,0);
    add(0,'0, 1,0,1,0, 1,1,'hD,2,0);
    add(0,'0, 1,0,0,0, 1,1,'hB,0,0);
    add(0,'0, 1,0,0,0, 1,1,'hC,1,0);
    add(0,'0, 1,1,0,0, 1,1,'hD,2,0);
    // roll + commit together with two in flight
    add(0,'0, 0,1,1,0, 1,0,'0, 2,0);
    add(0,'0, 1,0,0,0, 1,1,'hD,0,0);
    add(0,'0, 0,1,0,0, 1,0,'0, 1,0);
    // flush overrides enqueue, yumi and commit
    add(1,'hE,0,0,0,0, 1,0,'0, 0,1);
    add(1,'hF,1,0,0,0, 1,1,'hE,0,0);
    add(1,'h6,1,1,0,1, 1,1,'hF,1,0);
    add(1,'h7,0,0,0,0, 1,0,'0, 0,1);
    add(0,'0, 1,0,0,0, 1,1,'h7,0,0);
    add(0,'0, 0,1,0,0, 1,0,'0, 1,0);
    add(0,'0, 0,0,0,0, 1,0,'0, 0,1);

    foreach (vt[i]) begin
      @(negedge clk);
      chk($sformatf("v%0d.ready", i), PW'(issue_ready), PW'(vt[i].e_rdy));
      chk($sformatf("v%0d.v", i), PW'(disp_v), PW'(vt[i].e_v));
      if (vt[i].e_v) chk($sformatf("v%0d.pkt", i), disp_pkt, vt[i].e_pkt);
      chk($sformatf("v%0d.inflight", i), PW'(inflight), PW'(vt[i].e_inf));
      chk($sformatf("v%0d.empty", i), PW'(empty), PW'(vt[i].e_emp));
      drive(vt[i].iv, vt[i].pkt, vt[i].y, vt[i].c, vt[i].r, vt[i].f);
    end
    @(negedge clk);
    drive(0, '0, 0, 0, 0, 0);

    // 20 packets streamed through depth 4: order must survive five wraps
    sent = 0; nd = 0; m_infl = 0; cyc = 0;
    while ((nd < 20 || m_infl > 0) && cyc < 60) begin
      @(negedge clk);
      chk($sformatf("wrap%0d.inflight", cyc), PW'(inflight), PW'(m_infl));
      y_now = disp_v;
      c_now = (m_infl > 0);
      if (y_now) chk($sformatf("wrap.pkt%0d", nd), disp_pkt, PW'('h100 + nd));
      drive(sent < 20, PW'('h100 + sent), y_now, c_now, 0, 0);
      if (sent < 20) sent++;
      if (y_now) nd++;
      m_infl = m_infl + int'(y_now) - int'(c_now);
      cyc++;
    end
    chk("wrap.count", PW'(nd), PW'(20));
    @(negedge clk);
    drive(0, '0, 0, 0, 0, 0);

    // async reset with traffic in flight
    drive(1, PW'('h55), 0, 0, 0, 0);
    @(negedge clk);
    drive(1, PW'('h56), 1, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst.empty", PW'(empty), PW'(0));
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    chk_reset_vals("held_rst");
    drive(0, '0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_be_dispatch_queue.md
Name: bp_be_dispatch_queue

Overview:
- Producer side of the dispatch-packet interface: buffers issued dispatch packets and presents them, in order, to the reservation stage.
- Supports speculative dispatch. Entries stay resident after dispatch until committed, so a roll replays from the oldest uncommitted entry (e.g. on a long-latency miss or a late hazard).
- Flush discards all contents on a pipeline redirect.
- Sits between the issue/scoreboard logic and the reservation register in the calculator.

Parameters:
- pkt_width_p, 128, width of one dispatch packet; treated as opaque payload.
- els_p, 4, queue depth; must be a power of two, ≥ 2.
- ptr_width_lp, $clog2(els_p)+1, derived; pointer width including wrap bit.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  reset; asynchronous, active-low.
- issue_pkt_i  in  pkt_width_p  packet to enqueue.
- issue_v_i  in  1  enqueue request.
- issue_ready_o  out  1  queue can accept; enqueue occurs when issue_v_i & issue_ready_o.
- dispatch_pkt_o  out  pkt_width_p  oldest undispatched packet.
- dispatch_v_o  out  1  dispatch_pkt_o is valid.
- dispatch_yumi_i  in  1  consumer takes dispatch_pkt_o this cycle; legal only when dispatch_v_o.
- commit_i  in  1  retire oldest dispatched-uncommitted entry.
- roll_i  in  1  rewind dispatch to oldest uncommitted entry.
- flush_i  in  1  discard all entries.
- inflight_o  out  ptr_width_lp  count of dispatched-uncommitted entries.
- empty_o  out  1  no resident entries.

Behaviour:
- State: storage els_p x pkt_width_p (not reset) plus three wrap-bit pointers.
  - wptr: write pointer.
  - rptr: speculative read pointer.
  - cptr: commit pointer.
- Invariant: cptr ≤ rptr ≤ wptr in circular order.
- Derived counts:
  - resident = wptr - cptr.
  - pending = wptr - rptr.
  - inflight = rptr - cptr.
  - All arithmetic is modulo 2^ptr_width_lp.
- Reset (asynchronous, reset_i low): all pointers = 0. Therefore dispatch_v_o = 0, issue_ready_o = 1, inflight_o = 0, empty_o = 1. These values hold while reset_i is low.
- Outputs are combinational from registered state only; none depend on same-cycle inputs.
  - issue_ready_o = (resident != els_p).
  - dispatch_v_o = (pending != 0).
  - dispatch_pkt_o = mem[rptr].
  - inflight_o = inflight.
  - empty_o = (resident == 0).
- Enqueue: mem[wptr] <= issue_pkt_i and wptr + 1.
  - Enqueue-to-dispatch latency is one cycle; there is no bypass.
- Dispatch: dispatch_yumi_i → rptr + 1.
- Commit: commit_i → cptr + 1. Commit with inflight == 0 is illegal and is caught by an assertion.
- Roll: roll_i → rptr_next = cptr_next. Same-cycle dispatch_yumi_i is ignored; same-cycle commit applies first.
- Flush: flush_i → all pointers = 0. Same-cycle enqueue, yumi, commit and roll are ignored. Highest priority of all synchronous events.
- Priority: flush > roll > (commit, yumi, enqueue), which are mutually independent.
- Full with commit in the same cycle: issue_ready_o is still 0 (it is computed from current state). No enqueue that cycle; ready rises next cycle.
- Wrap-around: pointers wrap naturally; the wrap bit disambiguates full from empty.
- Reset asserted mid-operation: state clears immediately; packets in flight are lost; no partial writes are retained in the pointers.
- Assertions (simulation only):
  - yumi without dispatch_v_o.
  - commit with inflight == 0.
  - els_p not a power of two.

Decomposition:
- Shared package (bp_be_pkg): no new typedefs. The payload is bp_be_dispatch_pkt_s at instantiation; pkt_width_p is set from `bp_be_dispatch_pkt_width(vaddr_width_p).
- Sub-module bp_be_dispatch_queue_ptr: one circular wrap-bit counter with increment, load and clear, async active-low reset. Instantiated three times (wptr, rptr, cptr).
- Storage is a 1r1w register array.

Test Plan:
- Reset, then enqueue A,B,C on consecutive cycles with yumi held high from cycle 1 → dispatch_pkt_o = A,B,C on cycles 1,2,3; inflight_o = 1,2,3.
- Fill 4 entries with no dispatch → issue_ready_o = 0 and empty_o = 0. Then commit with yumi plus issue_v_i in the same cycle → no enqueue that cycle; ready returns to 1 the next cycle.
- Dispatch A,B,C, commit A, then roll with yumi in the same cycle → next cycle dispatch_pkt_o = B, inflight_o = 0, pending = 2.
- Roll and commit in the same cycle with inflight = 2 → rptr = cptr = old cptr + 1; inflight_o = 0.
- Flush with enqueue, yumi and commit all asserted → next cycle empty_o = 1, dispatch_v_o = 0, issue_ready_o = 1; the enqueued packet is not present.
- Run 20 enqueue/dispatch/commit cycles through a depth-4 queue (wrap 5 times), then assert reset_i low mid-stream → order preserved across wrap; all outputs return to reset values asynchronously.
